segment_scan_capture: RTL

- Receive-side monitor for the multiplexed 4-digit 7-segment display bus driven by the segment scan controller.
- Samples the one-hot anode select and the active-low cathode pattern, waits for each digit dwell to settle, then decodes the pattern back to a hex nibble per digit position.
- Publishes the reconstructed 4-digit value with per-digit validity and a frame-complete pulse.
- Used for on-chip loopback checking of the display path and as a bench scoreboard front end.

---
 rtl/segment_scan_capture.sv | 108 ++++++++++
 1 files changed

// File: rtl/segment_scan_capture.sv
// segment_scan_capture: rebuilds the hex value shown on a multiplexed 4-digit 7-segment scan bus,
// capturing each digit once its (anode, segment) sample has been stable for SETTLE_CYCLES.
module segment_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodeON,
  input  logic [6:0]  cathodeOFF,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  pattern_error,
  output logic        anode_fault,
  output logic        frame_done
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam logic [7:0]  SC = 8'(SETTLE_CYCLES);
  localparam logic [23:0] TL = 24'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [3:0]  a1, a2, prev_a, mask, mask_n;
  logic [6:0]  c1, c2, seg, prev_s;
  logic [7:0]  cnt, cnt_n;
  logic [23:0] tcnt;
  logic        one_hot, multi, same, active, cap, tout;
  logic [1:0]  idx;
  logic [4:0]  dec;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    seg     = ~c2;
    multi   = (a2 & (a2 - 4'd1)) != 4'd0;
    one_hot = a2 != 4'd0 && !multi;
    same    = {a2, seg} == {prev_a, prev_s};
    // a held digit only restarts the stability count when its sample changes
    active  = one_hot && !(state == HELD && same);
    cnt_n   = (state == SETTLE && same) ? cnt + 8'd1 : 8'd1;
    cap     = active && cnt_n == SC;
    tout    = !cap && tcnt == TL;
    idx     = {a2[3] | a2[2], a2[3] | a2[1]};
    dec     = decode(seg);
    mask_n  = mask | a2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1            <= '0;
      a2            <= '0;
      c1            <= '0;
      c2            <= '0;
      prev_a        <= '0;
      prev_s        <= '0;
      state         <= IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      mask          <= '0;
      digits        <= '0;
      digit_valid   <= '0;
      pattern_error <= '0;
      anode_fault   <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      a1          <= anodeON;
      a2          <= a1;
      c1          <= cathodeOFF;
      c2          <= c1;
      prev_a      <= a2;
      prev_s      <= seg;
      anode_fault <= anode_fault | multi;
      state       <= !one_hot ? IDLE : cap ? HELD : active ? SETTLE : state;
      frame_done  <= cap && mask_n == 4'hF;
      if (active) cnt <= cnt_n;
      if (cap) tcnt <= '0;
      else if (tcnt != TL + 24'd1) tcnt <= tcnt + 24'd1;
      if (cap) begin
        if (dec[4]) digits[{idx, 2'b00} +: 4] <= dec[3:0];
        else if (seg == 7'd0) digits[{idx, 2'b00} +: 4] <= 4'd0;
        else pattern_error <= pattern_error | a2;
        digit_valid <= dec[4] ? digit_valid | a2 : digit_valid & ~a2;
        mask        <= mask_n == 4'hF ? 4'd0 : mask_n;
      end else if (tout) begin
        digit_valid <= '0;
        mask        <= '0;
      end
    end
  end
endmodule
